// File: rtl/rans_pkg.sv
// rtl/rans_pkg.sv - shared widths, renormalization bound and controller state encoding for the rANS decoder slice
package rans_pkg;

  localparam int BYTE_W  = 8;
  localparam int STATE_W = 32;

  localparam logic [STATE_W-1:0] RANS_L_DEFAULT = 32'h0080_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEED,
    ST_EMIT,
    ST_RENORM,
    ST_DONE
  } rans_ctrl_state_t;

endpackage

// File: rtl/rans_stream_ctrl.sv
// rtl/rans_stream_ctrl.sv - streams the rANS state in from a byte stream, emits decoded symbols and renormalizes byte-wise
module rans_stream_ctrl
  import rans_pkg::*;
#(
  parameter logic [STATE_W-1:0] RANS_L = RANS_L_DEFAULT,
  parameter int                 CNT_W  = 24
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [CNT_W-1:0]   sym_count,
  input  logic [BYTE_W-1:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [STATE_W-1:0] rans_state,
  input  logic [STATE_W-1:0] new_rans_state,
  input  logic [BYTE_W-1:0]  dec_byte,
  output logic [BYTE_W-1:0]  out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done
);

  rans_ctrl_state_t   r_state;
  rans_ctrl_state_t   w_next;
  logic [STATE_W-1:0] r_rans_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [1:0]         r_seed_idx;

  logic               w_seed_take;
  logic               w_renorm_take;
  logic               w_out_fire;
  logic               w_last;
  logic [STATE_W-1:0] w_renorm_next;

  assign w_seed_take   = (r_state == ST_SEED) && in_valid;
  assign w_renorm_take = (r_state == ST_RENORM) && in_valid;
  assign w_out_fire    = (r_state == ST_EMIT) && out_ready;
  // A zero count can never reach EMIT; treating it as last keeps the FSM from locking up.
  assign w_last        = (r_cnt <= CNT_W'(1));
  assign w_renorm_next = {r_rans_state[STATE_W-BYTE_W-1:0], in_data};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next = (sym_count != '0) ? ST_SEED : ST_DONE;
      end
      ST_SEED: begin
        if (w_seed_take && (r_seed_idx == 2'd3)) w_next = ST_EMIT;
      end
      ST_EMIT: begin
        if (w_out_fire) begin
          if (w_last)                       w_next = ST_DONE;
          else if (new_rans_state < RANS_L) w_next = ST_RENORM;
        end
      end
      ST_RENORM: begin
        if (w_renorm_take && (w_renorm_next >= RANS_L)) w_next = ST_EMIT;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rans_state <= '0;
      r_cnt        <= '0;
      r_seed_idx   <= '0;
    end else begin
      if ((r_state == ST_IDLE) && start && (sym_count != '0)) begin
        r_cnt      <= sym_count;
        r_seed_idx <= '0;
      end
      // Little-endian seed: after four shifts the first byte sits in bits 7:0.
      if (w_seed_take) begin
        r_rans_state <= {in_data, r_rans_state[STATE_W-1:BYTE_W]};
        r_seed_idx   <= r_seed_idx + 2'd1;
      end
      if (w_out_fire) begin
        r_rans_state <= new_rans_state;
        if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_renorm_take) r_rans_state <= w_renorm_next;
    end
  end

  assign in_ready   = (r_state == ST_SEED) || (r_state == ST_RENORM);
  assign out_valid  = (r_state == ST_EMIT);
  assign out_data   = dec_byte;
  assign busy       = (r_state == ST_SEED) || (r_state == ST_EMIT) || (r_state == ST_RENORM);
  assign done       = (r_state == ST_DONE);
  assign rans_state = r_rans_state;

endmodule

// File: tb/tb_rans_stream_ctrl.sv
// tb/tb_rans_stream_ctrl.sv - directed checks of seeding, emit, renorm, stalls, zero length and reset abort
module tb_rans_stream_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [23:0] sym_count;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] rans_state;
  logic [31:0] new_rans_state;
  logic [7:0]  dec_byte;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rans_stream_ctrl dut (
    .clk            (clk),
    .resetn         (resetn),
    .start          (start),
    .sym_count      (sym_count),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .rans_state     (rans_state),
    .new_rans_state (new_rans_state),
    .dec_byte       (dec_byte),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .busy           (busy),
    .done           (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_rans_state"}, rans_state, 32'h0);
    chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'h0);
    chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'h0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'h0);
    chk({tag, "_done"}, {31'b0, done}, 32'h0);
  endtask

  // Call in cycle 1 (SEED); returns in the cycle after the fourth byte.
  task automatic feed_seed(input logic [31:0] v);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = v[8*i +: 8];
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic do_start(input logic [23:0] n);
    start     = 1'b1;
    sym_count = n;
    tick();
    start     = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; sym_count = '0; in_data = '0; in_valid = 1'b0;
    new_rans_state = '0; dec_byte = '0; out_ready = 1'b0;
    tick(); tick();
    chk_idle_outputs("reset");
    resetn = 1'b1;
    tick();

    // Seed a single symbol; last symbol must skip renorm even for a tiny state.
    do_start(24'd1);
    chk("seed_in_ready_c1", {31'b0, in_ready}, 32'h1);
    chk("seed_busy_c1", {31'b0, busy}, 32'h1);
    feed_seed(32'h1234_5678);
    chk("seed_state_c5", rans_state, 32'h1234_5678);
    chk("seed_out_valid_c5", {31'b0, out_valid}, 32'h1);
    chk("seed_in_ready_c5", {31'b0, in_ready}, 32'h0);
    dec_byte = 8'h41; new_rans_state = 32'h0000_0010; out_ready = 1'b1;
    chk("seed_out_data", {24'b0, out_data}, 32'h41);
    tick();
    out_ready = 1'b0;
    chk("seed_done", {31'b0, done}, 32'h1);
    chk("seed_no_renorm", {31'b0, in_ready}, 32'h0);
    chk("seed_done_not_valid", {31'b0, out_valid}, 32'h0);
    chk("seed_final_state", rans_state, 32'h0000_0010);
    tick();
    chk("seed_done_pulse", {31'b0, done}, 32'h0);
    chk("seed_idle_busy", {31'b0, busy}, 32'h0);

    // Backpressure then two-byte renorm.
    do_start(24'd2);
    feed_seed(32'h0403_0201);
    chk("bp_seed_state", rans_state, 32'h0403_0201);
    dec_byte = 8'h5A; new_rans_state = 32'h0000_1234;
    in_valid = 1'b1; in_data = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      chk("bp_out_valid", {31'b0, out_valid}, 32'h1);
      chk("bp_out_data", {24'b0, out_data}, 32'h5A);
      chk("bp_state_hold", rans_state, 32'h0403_0201);
      chk("bp_in_ready", {31'b0, in_ready}, 32'h0);
      tick();
    end
    chk("bp_state_after_stall", rans_state, 32'h0403_0201);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("rn_enter_in_ready", {31'b0, in_ready}, 32'h1);
    chk("rn_enter_state", rans_state, 32'h0000_1234);
    chk("rn_enter_out_valid", {31'b0, out_valid}, 32'h0);
    in_data = 8'hAB;
    tick();
    chk("rn_byte1_state", rans_state, 32'h0012_34AB);
    chk("rn_byte1_stay", {31'b0, in_ready}, 32'h1);
    in_data = 8'hCD;
    tick();
    in_valid = 1'b0;
    chk("rn_byte2_state", rans_state, 32'h1234_ABCD);
    chk("rn_back_to_emit", {31'b0, out_valid}, 32'h1);
    chk("rn_emit_in_ready", {31'b0, in_ready}, 32'h0);
    dec_byte = 8'h77; new_rans_state = 32'h0000_0005; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_last_done", {31'b0, done}, 32'h1);
    chk("bp_last_state", rans_state, 32'h0000_0005);
    tick();
    chk("bp_idle_busy", {31'b0, busy}, 32'h0);

    // Steady state: three symbols on three consecutive cycles, state at the bound.
    do_start(24'd3);
    feed_seed(32'h0080_0000);
    new_rans_state = 32'h0080_0000; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dec_byte = 8'(8'h30 + i);
      chk("ss_out_valid", {31'b0, out_valid}, 32'h1);
      chk("ss_out_data", {24'b0, out_data}, 32'h30 + 32'(i));
      tick();
    end
    out_ready = 1'b0;
    chk("ss_done", {31'b0, done}, 32'h1);
    tick();

    // Zero length job.
    do_start(24'd0);
    chk("zero_done_c1", {31'b0, done}, 32'h1);
    chk("zero_busy_c1", {31'b0, busy}, 32'h0);
    chk("zero_in_ready_c1", {31'b0, in_ready}, 32'h0);
    tick();
    chk("zero_done_c2", {31'b0, done}, 32'h0);
    chk("zero_busy_c2", {31'b0, busy}, 32'h0);
    chk("zero_in_ready_c2", {31'b0, in_ready}, 32'h0);

    // Gapped input during SEED.
    do_start(24'd1);
    in_valid = 1'b1; in_data = 8'h78; tick();
    in_valid = 1'b0; in_data = 8'h99;
    chk("gap_partial", rans_state[31:24], 32'h78);
    tick();
    chk("gap_hold", rans_state[31:24], 32'h78);
    in_valid = 1'b1; in_data = 8'h56; tick();
    in_valid = 1'b0; tick();
    in_valid = 1'b1; in_data = 8'h34; tick();
    in_valid = 1'b0; tick();
    in_valid = 1'b1; in_data = 8'h12;
    chk("gap_no_valid_c7", {31'b0, out_valid}, 32'h0);
    tick();
    in_valid = 1'b0;
    chk("gap_valid_c8", {31'b0, out_valid}, 32'h1);
    chk("gap_state_c8", rans_state, 32'h1234_5678);
    new_rans_state = 32'h0090_0000; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("gap_done", {31'b0, done}, 32'h1);
    tick();

    // Reset during RENORM aborts, then a fresh job seeds cleanly.
    do_start(24'd2);
    feed_seed(32'h1122_3344);
    new_rans_state = 32'h0000_0012; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("rst_in_renorm", {31'b0, in_ready}, 32'h1);
    in_valid = 1'b1; in_data = 8'h34;
    tick();
    in_valid = 1'b0;
    chk("rst_partial", rans_state, 32'h0000_1234);
    #2 resetn = 1'b0;
    #1;
    chk_idle_outputs("rst_async");
    tick();
    resetn = 1'b1;
    tick();
    chk_idle_outputs("rst_released");
    do_start(24'd1);
    feed_seed(32'hCAFE_F00D);
    chk("rst_reseed_state", rans_state, 32'hCAFE_F00D);
    chk("rst_reseed_valid", {31'b0, out_valid}, 32'h1);
    new_rans_state = 32'h0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("rst_reseed_done", {31'b0, done}, 32'h1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
